glitcbus_master: RTL and testbench

GLITCBUS_MASTER -- requirements
Module: glitcbus_master

---
 rtl/glitcbus_master.sv | 189 ++++++++++++++++++
 tb/tb_glitcbus_master.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/glitcbus_master.sv
// GLITCBUS master: serialises a 16-bit address and a 32-bit word over an 8-bit
// multiplexed bus. Reads wait READ_LATENCY turnaround cycles before the data bytes.
module glitcbus_master #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic        wr_i,
    input  logic        rd_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [31:0] dat_o,
    output logic        GSEL_B,
    output logic        GRDWR_B,
    output logic [7:0]  GAD_o,
    input  logic [7:0]  GAD_i,
    output logic        GAD_oe_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR_H = 3'd1,
        ADDR_L = 3'd2,
        WDATA  = 3'd3,
        TURN   = 3'd4,
        RDATA  = 3'd5,
        GAP    = 3'd6
    } state_t;

    localparam logic [3:0] TURN_LAST = 4'(READ_LATENCY - 1);

    state_t      state_r, next_state_s;
    logic        accept_s, is_read_s, is_read_r;
    logic [15:0] adr_s, adr_r;
    logic [31:0] dat_r, rd_shift_r, dat_o_r;
    logic [1:0]  byte_cnt_r, wbyte_idx_s;
    logic [3:0]  turn_cnt_r;
    logic [7:0]  wbyte_s, gad_s, gad_r;
    logic        gsel_b_s, grdwr_b_s, gad_oe_s;
    logic        gsel_b_r, grdwr_b_r, gad_oe_r, ack_r, busy_r;

    assign accept_s = (state_r == IDLE) && (wr_i || rd_i);

    // Outputs are registered from the next state, so accept-cycle values come straight from the inputs.
    always_comb begin
        if (state_r == IDLE) begin
            adr_s     = adr_i;
            is_read_s = rd_i & ~wr_i;
        end else begin
            adr_s     = adr_r;
            is_read_s = is_read_r;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = accept_s ? ADDR_H : IDLE;
            ADDR_H:  next_state_s = ADDR_L;
            ADDR_L:  next_state_s = is_read_r ? TURN : WDATA;
            WDATA:   next_state_s = (byte_cnt_r == 2'd3) ? GAP : WDATA;
            TURN:    next_state_s = (turn_cnt_r == TURN_LAST) ? RDATA : TURN;
            RDATA:   next_state_s = (byte_cnt_r == 2'd3) ? GAP : RDATA;
            GAP:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Write byte for the coming cycle, MSB first
    always_comb begin
        wbyte_idx_s = (state_r == WDATA) ? (byte_cnt_r + 2'd1) : 2'd0;
        case (wbyte_idx_s)
            2'd0:    wbyte_s = dat_r[31:24];
            2'd1:    wbyte_s = dat_r[23:16];
            2'd2:    wbyte_s = dat_r[15:8];
            2'd3:    wbyte_s = dat_r[7:0];
            default: wbyte_s = 8'h00;
        endcase
    end

    // Output decode for the next state
    always_comb begin
        gsel_b_s  = 1'b1;
        grdwr_b_s = 1'b1;
        gad_oe_s  = 1'b0;
        gad_s     = 8'h00;
        case (next_state_s)
            ADDR_H: begin
                gsel_b_s  = 1'b0;
                grdwr_b_s = is_read_s;
                gad_oe_s  = 1'b1;
                gad_s     = adr_s[15:8];
            end
            ADDR_L: begin
                gsel_b_s  = 1'b0;
                grdwr_b_s = is_read_s;
                gad_oe_s  = 1'b1;
                gad_s     = adr_s[7:0];
            end
            WDATA: begin
                gsel_b_s  = 1'b0;
                grdwr_b_s = 1'b0;
                gad_oe_s  = 1'b1;
                gad_s     = wbyte_s;
            end
            TURN, RDATA: begin
                gsel_b_s  = 1'b0;
                grdwr_b_s = 1'b1;
            end
            default: gad_s = 8'h00;
        endcase
    end

    // Transaction latch and phase counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adr_r      <= 16'h0000;
            dat_r      <= 32'h0000_0000;
            is_read_r  <= 1'b0;
            byte_cnt_r <= 2'd0;
            turn_cnt_r <= 4'd0;
        end else begin
            if (accept_s) begin
                adr_r     <= adr_i;
                dat_r     <= dat_i;
                is_read_r <= rd_i & ~wr_i;
            end
            byte_cnt_r <= (state_r == WDATA || state_r == RDATA) ? (byte_cnt_r + 2'd1) : 2'd0;
            turn_cnt_r <= (state_r == TURN) ? (turn_cnt_r + 4'd1) : 4'd0;
        end
    end

    // Read assembly; dat_o only changes when the last byte lands
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_shift_r <= 32'h0000_0000;
            dat_o_r    <= 32'h0000_0000;
        end else begin
            if (accept_s) begin
                rd_shift_r <= 32'h0000_0000;
            end else if (state_r == RDATA) begin
                rd_shift_r <= {rd_shift_r[23:0], GAD_i};
            end
            if (state_r == RDATA && next_state_s == GAP) begin
                dat_o_r <= {rd_shift_r[23:0], GAD_i};
            end
        end
    end

    // Registered bus and handshake outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gsel_b_r  <= 1'b1;
            grdwr_b_r <= 1'b1;
            gad_oe_r  <= 1'b0;
            gad_r     <= 8'h00;
            ack_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            gsel_b_r  <= gsel_b_s;
            grdwr_b_r <= grdwr_b_s;
            gad_oe_r  <= gad_oe_s;
            gad_r     <= gad_s;
            ack_r     <= (next_state_s == GAP);
            busy_r    <= (next_state_s != IDLE);
        end
    end

    assign GSEL_B   = gsel_b_r;
    assign GRDWR_B  = grdwr_b_r;
    assign GAD_oe_o = gad_oe_r;
    assign GAD_o    = gad_r;
    assign ack_o    = ack_r;
    assign busy_o   = busy_r;
    assign dat_o    = dat_o_r;

endmodule

// File: tb/tb_glitcbus_master.sv
// Directed bench for glitcbus_master: cycle-exact checks of write, read,
// collision, back-to-back and reset-abort sequences plus a passive bus monitor.
module tb_glitcbus_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] adr_i;
    logic [31:0] dat_i;
    logic        wr_i, rd_i;
    logic        busy_o, ack_o;
    logic [31:0] dat_o;
    logic        GSEL_B, GRDWR_B, GAD_oe_o;
    logic [7:0]  GAD_o, GAD_i;

    int   checks_cnt = 0;
    int   errors_cnt = 0;
    logic slave_drv  = 1'b0;
    logic prev_sel_low = 1'b0;
    logic prev_rdwr    = 1'b1;

    glitcbus_master #(.READ_LATENCY(2)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .adr_i    (adr_i),
        .dat_i    (dat_i),
        .wr_i     (wr_i),
        .rd_i     (rd_i),
        .busy_o   (busy_o),
        .ack_o    (ack_o),
        .dat_o    (dat_o),
        .GSEL_B   (GSEL_B),
        .GRDWR_B  (GRDWR_B),
        .GAD_o    (GAD_o),
        .GAD_i    (GAD_i),
        .GAD_oe_o (GAD_oe_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic exp_bus(input string tag, input logic sel, input logic rdwr, input logic oe,
                           input logic [7:0] gad, input logic ack, input logic busy);
        check_val({tag, ".sel"}, 32'(GSEL_B), 32'(sel));
        if (!sel) check_val({tag, ".rdwr"}, 32'(GRDWR_B), 32'(rdwr));
        check_val({tag, ".oe"}, 32'(GAD_oe_o), 32'(oe));
        if (oe) check_val({tag, ".gad"}, 32'(GAD_o), 32'(gad));
        check_val({tag, ".ack"}, 32'(ack_o), 32'(ack));
        check_val({tag, ".busy"}, 32'(busy_o), 32'(busy));
    endtask

    // Caller is in accept cycle T with the request driven; returns in the GAP cycle T+7.
    task automatic write_phase(input string tag, input logic [15:0] a, input logic [31:0] d,
                               input bit hold, input bit pulse_rd,
                               input logic [15:0] na, input logic [31:0] nd);
        logic [7:0] exp_b [6];
        exp_b = '{a[15:8], a[7:0], d[31:24], d[23:16], d[15:8], d[7:0]};
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                if (hold) begin
                    adr_i = na;
                    dat_i = nd;
                end else begin
                    wr_i = 1'b0;
                    rd_i = 1'b0;
                end
            end
            if (pulse_rd && k == 3) rd_i = 1'b1;
            if (pulse_rd && k == 4) rd_i = 1'b0;
            exp_bus($sformatf("%s.t%0d", tag, k + 1), 1'b0, 1'b0, 1'b1, exp_b[k], 1'b0, 1'b1);
        end
        tick();
        exp_bus({tag, ".gap"}, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    // Bus monitor: no contention with the slave, direction stable while selected
    always @(negedge clk_i) begin
        if (slave_drv) check_val("mon.oe_vs_slave", 32'(GAD_oe_o), 32'd0);
        if (prev_sel_low && !GSEL_B) check_val("mon.rdwr_stable", 32'(GRDWR_B), 32'(prev_rdwr));
        prev_sel_low <= !GSEL_B;
        prev_rdwr    <= GRDWR_B;
    end

    initial begin
        int         acks;
        int         busies;
        logic [7:0] rd_bytes [4];
        rd_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};

        rst_i = 1'b1; wr_i = 1'b0; rd_i = 1'b0;
        adr_i = 16'h0000; dat_i = 32'h0; GAD_i = 8'h00;
        tick();
        tick();
        exp_bus("rst", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("rst.rdwr", 32'(GRDWR_B), 32'd1);
        check_val("rst.gad", 32'(GAD_o), 32'd0);
        check_val("rst.dat_o", dat_o, 32'h0);
        rst_i = 1'b0;
        tick();

        // Plain write with a read pulse at T+4 that must be ignored
        wr_i = 1'b1; adr_i = 16'h0823; dat_i = 32'hDEADBEEF;
        write_phase("wr", 16'h0823, 32'hDEADBEEF, 1'b0, 1'b1, 16'h0, 32'h0);
        tick();
        exp_bus("wr.idle", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("wr.idle_rdwr", 32'(GRDWR_B), 32'd1);
        check_val("wr.idle_gad", 32'(GAD_o), 32'd0);
        check_val("wr.dat_o", dat_o, 32'h0);

        // Read, latency 2
        rd_i = 1'b1; adr_i = 16'h0010;
        tick();
        rd_i = 1'b0;
        exp_bus("rd.t1", 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        tick();
        exp_bus("rd.t2", 1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            exp_bus($sformatf("rd.turn%0d", k), 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            GAD_i = rd_bytes[k];
            slave_drv = 1'b1;
            exp_bus($sformatf("rd.data%0d", k), 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        tick();
        slave_drv = 1'b0; GAD_i = 8'h00;
        exp_bus("rd.gap", 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        check_val("rd.dat_o", dat_o, 32'h12345678);
        tick();
        exp_bus("rd.idle", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("rd.dat_o_hold", dat_o, 32'h12345678);

        // Simultaneous write and read: write wins, nothing follows
        wr_i = 1'b1; rd_i = 1'b1; adr_i = 16'hA5C3; dat_i = 32'h01020304;
        write_phase("both", 16'hA5C3, 32'h01020304, 1'b0, 1'b0, 16'h0, 32'h0);
        acks = 0;
        busies = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            acks   += int'(ack_o);
            busies += int'(busy_o);
        end
        check_val("both.extra_acks", 32'(acks), 32'd0);
        check_val("both.extra_busy", 32'(busies), 32'd0);
        check_val("both.dat_o", dat_o, 32'h12345678);

        // Back-to-back writes with the request held high
        wr_i = 1'b1; adr_i = 16'h1122; dat_i = 32'hAABBCCDD;
        write_phase("b2b1", 16'h1122, 32'hAABBCCDD, 1'b1, 1'b0, 16'h3344, 32'h55667788);
        tick();
        exp_bus("b2b.t8", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        write_phase("b2b2", 16'h3344, 32'h55667788, 1'b0, 1'b0, 16'h0, 32'h0);
        tick();
        exp_bus("b2b.idle", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset during RDATA aborts the read
        rd_i = 1'b1; adr_i = 16'h00FF;
        tick();
        rd_i = 1'b0;
        exp_bus("ab.t1", 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        tick();
        exp_bus("ab.t2", 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        GAD_i = 8'hAB; slave_drv = 1'b1;
        exp_bus("ab.data0", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        GAD_i = 8'hCD; rst_i = 1'b1;
        exp_bus("ab.data1", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        slave_drv = 1'b0; GAD_i = 8'h00;
        exp_bus("ab.after", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("ab.dat_o", dat_o, 32'h0);

        // Request in the first cycle after reset is accepted
        rst_i = 1'b0; wr_i = 1'b1; adr_i = 16'hBEEF; dat_i = 32'h0BADF00D;
        write_phase("postrst", 16'hBEEF, 32'h0BADF00D, 1'b0, 1'b0, 16'h0, 32'h0);
        tick();
        exp_bus("postrst.idle", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("postrst.dat_o", dat_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
